// File: rtl/mem_access_controller.sv
// ---------------------------------------------------------------------------
// mem_access_controller
//
// Sequencer between the CPU load/store stage and the data memory subsystem.
// The memory side only sees aligned 32-bit word accesses.
//   - Loads: one read cycle. The addressed byte/half lane is extracted and
//     sign- or zero-extended into resp_rdata_out.
//   - Word stores: one write cycle.
//   - Byte/half stores: read-modify-write. The old word is read, the target
//     lane is replaced, and the merged word is written back.
// Each accepted request ends with a one-cycle resp_valid_out pulse.
//
// Optional feature (macro MEM_ALIGN_CHECK_EN):
//   Adds resp_fault_out. A misaligned half or word request skips memory
//   entirely and responds with fault=1 and rdata=0.
//   When the macro is undefined, low address bits are simply truncated.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   req_valid_in/ready    request handshake (ready only while idle)
//   req_we_in             1=store, 0=load
//   req_size_in           00 byte, 01 half, 1x word
//   req_sign_in           sign-extend load result
//   req_addr_in           byte address
//   req_wdata_in          store data, right-justified for byte/half
//   resp_valid_out        one-cycle completion pulse
//   resp_rdata_out        load result (0 for stores), held until next response
//   mem_addr_out          word-aligned address to memory
//   mem_writedata_out     word written to memory
//   mem_re_out/mem_we_out read/write enables (mutually exclusive)
//   mem_size_out          always word (2'b11)
//   mem_sign_out          always 0
//   mem_readdata_in       combinational read data for mem_addr_out
//   resp_fault_out        (MEM_ALIGN_CHECK_EN only) misaligned request flag
// ---------------------------------------------------------------------------
module mem_access_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic              req_we_in,
    input  logic [1:0]        req_size_in,
    input  logic              req_sign_in,
    input  logic [ADDR_W-1:0] req_addr_in,
    input  logic [DATA_W-1:0] req_wdata_in,
    output logic              resp_valid_out,
    output logic [DATA_W-1:0] resp_rdata_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_writedata_out,
    output logic              mem_re_out,
    output logic              mem_we_out,
    output logic [1:0]        mem_size_out,
    output logic              mem_sign_out,
    input  logic [DATA_W-1:0] mem_readdata_in
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              resp_fault_out
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
`ifdef MEM_ALIGN_CHECK_EN
        ,
        ST_FAULT
`endif
    } state_t;

    state_t state;
    state_t next_state;

    // Latched request
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    // Old word captured during the read half of a read-modify-write
    logic [DATA_W-1:0] old_word_q;

    // Response data register; only changes on the transition into RESP
    logic [DATA_W-1:0] rdata_q;

    logic              accept;

`ifdef MEM_ALIGN_CHECK_EN
    logic              fault_q;
`endif

    // Pick the addressed lane out of a little-endian word and extend it.
    // size[1] set means a full word (size 2'b10 behaves like 2'b11).
    function automatic logic [31:0] extract_lane(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  offs,
        input logic        sign
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{offs, 3'b000} +: 8];
        h = offs[1] ? word[31:16] : word[15:0];
        if (size[1]) begin
            r = word;
        end else if (size[0]) begin
            r = {{16{sign & h[15]}}, h};
        end else begin
            r = {{24{sign & b[7]}}, b};
        end
        return r;
    endfunction

    // Replace the target lane of the old word with right-justified store
    // data; all other bytes pass through unchanged.
    function automatic logic [31:0] merge_lane(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  offs
    );
        logic [31:0] r;
        r = old_word;
        if (size[1]) begin
            r = wdata;
        end else if (size[0]) begin
            r[{offs[1], 4'b0000} +: 16] = wdata[15:0];
        end else begin
            r[{offs, 3'b000} +: 8] = wdata[7:0];
        end
        return r;
    endfunction

`ifdef MEM_ALIGN_CHECK_EN
    // Halves must be 2-byte aligned and words 4-byte aligned; bytes never fault
    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] offs
    );
        logic r;
        r = 1'b0;
        if (size[1]) begin
            r = (offs != 2'b00);
        end else if (size[0]) begin
            r = offs[0];
        end
        return r;
    endfunction
`endif

    // The memory always sees word accesses on the latched, aligned address
    assign mem_addr_out   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_size_out   = 2'b11;
    assign mem_sign_out   = 1'b0;
    assign resp_rdata_out = rdata_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign resp_fault_out = fault_q;
`endif

    // State register. Reset is asynchronous, so the memory enables (decoded
    // from state) drop as soon as reset rises and an unfinished RMW never
    // reaches its write edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode. Enables are only ever set in ACCESS and
    // the two RMW states, so re/we are exclusive and low in IDLE and RESP.
    always_comb begin
        next_state        = state;
        req_ready_out     = 1'b0;
        resp_valid_out    = 1'b0;
        mem_re_out        = 1'b0;
        mem_we_out        = 1'b0;
        mem_writedata_out = '0;
        accept            = 1'b0;

        case (state)
            ST_IDLE: begin
                req_ready_out = 1'b1;
                if (req_valid_in) begin
                    accept = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                    if (is_misaligned(req_size_in, req_addr_in[1:0])) begin
                        next_state = ST_FAULT;
                    end else
`endif
                    if (req_we_in && !req_size_in[1]) begin
                        next_state = ST_RMW_RD;
                    end else begin
                        next_state = ST_ACCESS;
                    end
                end
            end

            ST_ACCESS: begin
                if (we_q) begin
                    mem_we_out        = 1'b1;
                    mem_writedata_out = wdata_q;
                end else begin
                    mem_re_out = 1'b1;
                end
                next_state = ST_RESP;
            end

            ST_RMW_RD: begin
                mem_re_out = 1'b1;
                next_state = ST_RMW_WR;
            end

            ST_RMW_WR: begin
                mem_we_out        = 1'b1;
                mem_writedata_out = merge_lane(old_word_q, wdata_q, size_q, addr_q[1:0]);
                next_state        = ST_RESP;
            end

            ST_RESP: begin
                resp_valid_out = 1'b1;
                next_state     = ST_IDLE;
            end

`ifdef MEM_ALIGN_CHECK_EN
            ST_FAULT: begin
                next_state = ST_RESP;
            end
`endif

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Request latch, RMW old-word capture and response data. The response
    // registers are written only on the edge that enters RESP, so the last
    // result stays visible until the next response replaces it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            size_q     <= 2'b00;
            sign_q     <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            old_word_q <= '0;
            rdata_q    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                addr_q  <= req_addr_in;
                size_q  <= req_size_in;
                sign_q  <= req_sign_in;
                we_q    <= req_we_in;
                wdata_q <= req_wdata_in;
            end

            case (state)
                ST_ACCESS: begin
                    if (we_q) begin
                        rdata_q <= '0;
                    end else begin
                        rdata_q <= extract_lane(mem_readdata_in, size_q, addr_q[1:0], sign_q);
                    end
`ifdef MEM_ALIGN_CHECK_EN
                    fault_q <= 1'b0;
`endif
                end

                ST_RMW_RD: begin
                    old_word_q <= mem_readdata_in;
                end

                ST_RMW_WR: begin
                    rdata_q <= '0;
`ifdef MEM_ALIGN_CHECK_EN
                    fault_q <= 1'b0;
`endif
                end

`ifdef MEM_ALIGN_CHECK_EN
                ST_FAULT: begin
                    rdata_q <= '0;
                    fault_q <= 1'b1;
                end
`endif

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// ---------------------------------------------------------------------------
// tb_mem_access_controller
//
// Directed test of mem_access_controller with a small behavioural memory
// (a data segment at 0x10000000..0x1000003F and one stack word at
// 0x7FFFFFFC; everything else reads as 0). Each accepted request pushes its
// hand-computed expected response onto a scoreboard queue; a separate
// monitor pops and compares whenever resp_valid_out is seen. It also checks
// the response cycle, the number of memory read/write cycles, the memory
// address and the written word.
// Compile with +define+MEM_ALIGN_CHECK_EN to exercise the fault feature.
// ---------------------------------------------------------------------------
module tb_mem_access_controller;

    logic        clock;
    logic        reset;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_we_in;
    logic [1:0]  req_size_in;
    logic        req_sign_in;
    logic [31:0] req_addr_in;
    logic [31:0] req_wdata_in;
    logic        resp_valid_out;
    logic [31:0] resp_rdata_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_writedata_out;
    logic        mem_re_out;
    logic        mem_we_out;
    logic [1:0]  mem_size_out;
    logic        mem_sign_out;
    logic [31:0] mem_readdata_in;
`ifdef MEM_ALIGN_CHECK_EN
    logic        resp_fault_out;
`endif

    mem_access_controller dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid_in      (req_valid_in),
        .req_ready_out     (req_ready_out),
        .req_we_in         (req_we_in),
        .req_size_in       (req_size_in),
        .req_sign_in       (req_sign_in),
        .req_addr_in       (req_addr_in),
        .req_wdata_in      (req_wdata_in),
        .resp_valid_out    (resp_valid_out),
        .resp_rdata_out    (resp_rdata_out),
        .mem_addr_out      (mem_addr_out),
        .mem_writedata_out (mem_writedata_out),
        .mem_re_out        (mem_re_out),
        .mem_we_out        (mem_we_out),
        .mem_size_out      (mem_size_out),
        .mem_sign_out      (mem_sign_out),
        .mem_readdata_in   (mem_readdata_in)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .resp_fault_out    (resp_fault_out)
`endif
    );

    typedef struct {
        int          id;
        logic [31:0] rdata;
        int          resp_cycle;
        int          n_re;
        int          n_we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          next_id;
    int          cyc;
    int          n_compared;
    int          n_mismatched;
    int          re_since;
    int          we_since;
    int          total_we;
    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;

    // Behavioural memory
    logic [31:0] data_seg [0:15];
    logic [31:0] stack_word;
    logic        load_mem;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Combinational read port; unmapped addresses return 0
    always_comb begin
        mem_readdata_in = 32'h0;
        if (mem_addr_out[31:6] == 26'h0400000) begin
            mem_readdata_in = data_seg[mem_addr_out[5:2]];
        end else if (mem_addr_out == 32'h7FFFFFFC) begin
            mem_readdata_in = stack_word;
        end
    end

    // Write port commits on the rising edge; preload while load_mem is set
    always @(posedge clock) begin
        if (load_mem) begin
            for (int i = 0; i < 16; i++) data_seg[i] <= 32'h0;
            data_seg[0] <= 32'h11223344;
            data_seg[1] <= 32'h8899AABB;
            stack_word  <= 32'h0;
        end else if (mem_we_out) begin
            if (mem_addr_out[31:6] == 26'h0400000) begin
                data_seg[mem_addr_out[5:2]] <= mem_writedata_out;
            end else if (mem_addr_out == 32'h7FFFFFFC) begin
                stack_word <= mem_writedata_out;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: counts memory cycles between responses and checks each
    // response against the oldest scoreboard entry
    always @(negedge clock) begin
        if (mem_we_out) total_we++;
        if (reset) begin
            re_since = 0;
            we_since = 0;
        end else begin
            if (mem_re_out && mem_we_out) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL re_we_exclusive: got re=1 we=1 at cycle %0d, expected at most one", cyc);
            end
            if (mem_re_out) begin
                re_since++;
                seen_addr = mem_addr_out;
            end
            if (mem_we_out) begin
                we_since++;
                seen_addr  = mem_addr_out;
                seen_wdata = mem_writedata_out;
            end
            if (resp_valid_out) begin
                if (sb.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_resp: got resp_valid_out at cycle %0d, expected none", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput($sformatf("resp#%0d rdata", mon_e.id), resp_rdata_out, mon_e.rdata);
                    checkOutput($sformatf("resp#%0d cycle", mon_e.id), cyc, mon_e.resp_cycle);
                    checkOutput($sformatf("resp#%0d re_cycles", mon_e.id), re_since, mon_e.n_re);
                    checkOutput($sformatf("resp#%0d we_cycles", mon_e.id), we_since, mon_e.n_we);
                    checkOutput($sformatf("resp#%0d enables_in_resp", mon_e.id), {31'h0, mem_re_out | mem_we_out}, 32'h0);
                    if (mon_e.n_re + mon_e.n_we > 0)
                        checkOutput($sformatf("resp#%0d mem_addr", mon_e.id), seen_addr, mon_e.addr);
                    if (mon_e.n_we > 0)
                        checkOutput($sformatf("resp#%0d writedata", mon_e.id), seen_wdata, mon_e.wdata);
`ifdef MEM_ALIGN_CHECK_EN
                    checkOutput($sformatf("resp#%0d fault", mon_e.id), {31'h0, resp_fault_out}, {31'h0, mon_e.fault});
`endif
                end
                re_since = 0;
                we_since = 0;
            end else if (sb.size() > 0 && cyc > sb[0].resp_cycle) begin
                mon_e = sb.pop_front();
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL resp#%0d missing: got no response by cycle %0d, expected at cycle %0d",
                         mon_e.id, cyc, mon_e.resp_cycle);
            end
        end
    end

    // Drive one request, wait (bounded) for acceptance, and queue the
    // expected response. Called just after a rising edge.
    task automatic applyStimulus(
        input  logic        we,
        input  logic [1:0]  size,
        input  logic        sign,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [31:0] exp_rdata,
        input  int          lat,
        input  int          n_re,
        input  int          n_we,
        input  logic [31:0] exp_addr,
        input  logic [31:0] exp_wdata,
        input  logic        exp_fault,
        input  bit          push,
        output int          acc_cyc,
        output int          waited
    );
        exp_t e;
        req_we_in    = we;
        req_size_in  = size;
        req_sign_in  = sign;
        req_addr_in  = addr;
        req_wdata_in = wdata;
        req_valid_in = 1'b1;
        acc_cyc      = -1;
        waited       = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (req_ready_out) begin
                acc_cyc = cyc;
                break;
            end
            waited++;
        end
        if (acc_cyc < 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL accept: got no req_ready_out for addr %h, expected acceptance within 20 cycles", addr);
            req_valid_in = 1'b0;
            return;
        end
        if (push) begin
            e.id         = next_id;
            e.rdata      = exp_rdata;
            e.resp_cycle = acc_cyc + lat;
            e.n_re       = n_re;
            e.n_we       = n_we;
            e.addr       = exp_addr;
            e.wdata      = exp_wdata;
            e.fault      = exp_fault;
            sb.push_back(e);
            next_id++;
        end
        @(posedge clock);
        #1;
        req_valid_in = 1'b0;
    endtask

    task automatic loadReq(input logic [1:0] size, input logic sign, input logic [31:0] addr,
                           input logic [31:0] exp_rdata, input logic [31:0] exp_addr);
        int a;
        int w;
        applyStimulus(1'b0, size, sign, addr, 32'h0, exp_rdata, 2, 1, 0, exp_addr, 32'h0, 1'b0, 1'b1, a, w);
    endtask

    task automatic storeReq(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                            input int lat, input int n_re, input logic [31:0] exp_addr,
                            input logic [31:0] exp_wdata);
        int a;
        int w;
        applyStimulus(1'b1, size, 1'b0, addr, wdata, 32'h0, lat, n_re, 1, exp_addr, exp_wdata, 1'b0, 1'b1, a, w);
    endtask

    initial begin
        int acc1;
        int acc2;
        int wt;
        int we_before;
        int rel_cyc;

        reset        = 1'b1;
        load_mem     = 1'b1;
        req_valid_in = 1'b0;
        req_we_in    = 1'b0;
        req_size_in  = 2'b00;
        req_sign_in  = 1'b0;
        req_addr_in  = 32'h0;
        req_wdata_in = 32'h0;

        // Reset state
        @(negedge clock);
        checkOutput("reset ready", {31'h0, req_ready_out}, 32'h1);
        checkOutput("reset resp_valid", {31'h0, resp_valid_out}, 32'h0);
        checkOutput("reset rdata", resp_rdata_out, 32'h0);
        checkOutput("reset mem_re", {31'h0, mem_re_out}, 32'h0);
        checkOutput("reset mem_we", {31'h0, mem_we_out}, 32'h0);
        checkOutput("reset mem_addr", mem_addr_out, 32'h0);
        checkOutput("reset writedata", mem_writedata_out, 32'h0);
        checkOutput("reset mem_size", {30'h0, mem_size_out}, 32'h3);
        @(posedge clock);
        #1;
        load_mem = 1'b0;
        reset    = 1'b0;

        // Loads from word 0x8899AABB @0x10000004
        loadReq(2'b00, 1'b1, 32'h10000006, 32'hFFFFFF99, 32'h10000004);
        loadReq(2'b01, 1'b0, 32'h10000004, 32'h0000AABB, 32'h10000004);
        loadReq(2'b01, 1'b1, 32'h10000004, 32'hFFFFAABB, 32'h10000004);
        loadReq(2'b00, 1'b0, 32'h10000007, 32'h00000088, 32'h10000004);
        loadReq(2'b01, 1'b1, 32'h10000006, 32'hFFFF8899, 32'h10000004);
        loadReq(2'b00, 1'b1, 32'h10000004, 32'hFFFFFFBB, 32'h10000004);
        loadReq(2'b10, 1'b1, 32'h10000004, 32'h8899AABB, 32'h10000004);

        // Byte and half RMW stores on 0x11223344 @0x10000000, each read back
        storeReq(2'b00, 32'h10000001, 32'hABCDEFEE, 3, 1, 32'h10000000, 32'h1122EE44);
        loadReq(2'b11, 1'b0, 32'h10000000, 32'h1122EE44, 32'h10000000);
        storeReq(2'b01, 32'h10000002, 32'hFFFF1234, 3, 1, 32'h10000000, 32'h1234EE44);
        loadReq(2'b11, 1'b0, 32'h10000000, 32'h1234EE44, 32'h10000000);

        // Word store then back-to-back word load of the stack word
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h7FFFFFFC, 32'hDEADBEEF, 32'h0, 2, 0, 1,
                      32'h7FFFFFFC, 32'hDEADBEEF, 1'b0, 1'b1, acc1, wt);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h7FFFFFFC, 32'h0, 32'hDEADBEEF, 2, 1, 0,
                      32'h7FFFFFFC, 32'h0, 1'b0, 1'b1, acc2, wt);
        checkOutput("b2b accept_cycle", acc2, acc1 + 3);
        checkOutput("b2b busy_cycles", wt, 32'd2);

        // Unmapped address reads as 0
        loadReq(2'b11, 1'b0, 32'h20000000, 32'h0, 32'h20000000);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned word load, half load and word store fault without memory cycles
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h10000002, 32'h0, 32'h0, 2, 0, 0,
                      32'h0, 32'h0, 1'b1, 1'b1, acc1, wt);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h10000005, 32'h0, 32'h0, 2, 0, 0,
                      32'h0, 32'h0, 1'b1, 1'b1, acc1, wt);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h10000001, 32'hCAFEF00D, 32'h0, 2, 0, 0,
                      32'h0, 32'h0, 1'b1, 1'b1, acc1, wt);
        loadReq(2'b11, 1'b0, 32'h10000000, 32'h1234EE44, 32'h10000000);
`else
        // Misaligned addresses truncate to the containing word / half
        loadReq(2'b11, 1'b0, 32'h10000002, 32'h1234EE44, 32'h10000000);
        loadReq(2'b01, 1'b0, 32'h10000005, 32'h0000AABB, 32'h10000004);
`endif

        // Reset during RMW_RD of a half store: nothing is written, no response
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h10000004, 32'h00005555, 32'h0, 3, 1, 1,
                      32'h10000004, 32'h0, 1'b0, 1'b0, acc1, wt);
        we_before = total_we;
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort mem_we_async", {31'h0, mem_we_out}, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        req_we_in    = 1'b0;
        req_size_in  = 2'b11;
        req_addr_in  = 32'h10000004;
        req_valid_in = 1'b1;
        reset        = 1'b0;
        rel_cyc      = cyc;
        checkOutput("abort ready_after_release", {31'h0, req_ready_out}, 32'h1);
        checkOutput("abort no_write", total_we, we_before);
        checkOutput("abort memory_word", data_seg[1], 32'h8899AABB);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h10000004, 32'h0, 32'h8899AABB, 2, 1, 0,
                      32'h10000004, 32'h0, 1'b0, 1'b1, acc1, wt);
        checkOutput("release accept_cycle", acc1, rel_cyc);

        // Drain the scoreboard (bounded)
        for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clock);
        if (sb.size() > 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL drain: got %0d outstanding responses, expected 0", sb.size());
        end
        repeat (3) @(negedge clock);
        checkOutput("final memory_word0", data_seg[0], 32'h1234EE44);
        checkOutput("final stack_word", stack_word, 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Sequencer between the CPU load/store stage and the data memory subsystem (data/stack/serial segments).
- Issues only aligned word accesses to memory.
- Extracts byte/half lanes on loads, with sign/zero extension.
- Performs byte/half stores as a read-modify-write (RMW) sequence.
- Uses a valid/ready request handshake and a one-cycle response pulse.

Parameters:
- ADDR_W, 32, address width (memory side uses the full width).
- DATA_W, 32, data width; fixed at 32, no other value supported.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid_in  in  1  request present
- req_ready_out  out  1  controller can accept a request this cycle
- req_we_in  in  1  1=store, 0=load
- req_size_in  in  2  00 byte, 01 half, 11 word; 10 treated as word
- req_sign_in  in  1  sign-extend load result
- req_addr_in  in  32  byte address
- req_wdata_in  in  32  store data, right-justified for byte/half
- resp_valid_out  out  1  one-cycle pulse: access complete
- resp_rdata_out  out  32  load result; 0 for stores
- mem_addr_out  out  32  word address, {addr[31:2],2'b00}
- mem_writedata_out  out  32  write word
- mem_re_out  out  1  read enable
- mem_we_out  out  1  write enable; memory commits on the rising edge
- mem_size_out  out  2  constant 2'b11
- mem_sign_out  out  1  constant 0
- mem_readdata_in  in  32  combinational read data, valid in the same cycle as the address

Behaviour:
- Reset values:
  - state IDLE
  - req_ready_out=1, resp_valid_out=0, resp_rdata_out=0
  - mem_re_out=0, mem_we_out=0, mem_addr_out=0, mem_writedata_out=0
  - all request registers 0
- States:
  - IDLE: ready=1. On valid&ready, latch addr/size/sign/we/wdata.
    - Word access or load -> ACCESS.
    - Byte/half store -> RMW_RD.
  - ACCESS: drive re (load) or we (store) with the latched word address.
    - Load: capture mem_readdata_in at the cycle-end edge.
    - Go to RESP.
  - RMW_RD: re=1. Capture the old word, go to RMW_WR.
  - RMW_WR: we=1, writedata = old word with the target lane replaced. Go to RESP.
  - RESP: resp_valid_out=1 for exactly one cycle, then IDLE. ready=0.
- req_ready_out=1 only in IDLE; a request is never accepted while busy.
- mem_re_out and mem_we_out are never both 1, and are 0 in IDLE and RESP.
- Latency, with acceptance edge at cycle T:
  - word load, word store, sub-word load: resp_valid_out in cycle T+2
  - sub-word store: resp_valid_out in cycle T+3
- Lanes are little-endian:
  - byte n = bits [8n+7:8n], n = addr[1:0]
  - half uses addr[1]: 0 -> [15:0], 1 -> [31:16]
- Load result:
  - selected lane, sign-extended if sign=1, else zero-extended
  - held in resp_rdata_out from RESP until the next RESP
- Store merge:
  - byte: wdata[7:0] into lane addr[1:0]
  - half: wdata[15:0] into half addr[1]
  - the other bytes come from the captured old word unchanged
- Address handling (macro off):
  - addr[1:0] ignored for words
  - addr[0] ignored for halves
- Unmapped address: memory returns 0; the controller applies no special case.
- Reset asserted mid-operation:
  - immediate return to IDLE; mem_we_out drops asynchronously
  - an RMW aborted before the RMW_WR edge writes nothing
  - no resp_valid_out for the aborted request
- A req_valid_in held across reset deassertion is accepted on the first clock edge after release.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined:
  - adds port resp_fault_out (out, 1), reset 0
  - a misaligned request (half with addr[0]=1; word with addr[1:0]!=0) goes IDLE->FAULT->RESP
  - no mem_re_out/mem_we_out is asserted for it
  - resp_valid_out in T+2 with resp_fault_out=1 and resp_rdata_out=0
  - resp_fault_out=0 on every aligned response
- When undefined: no port, no FAULT state; misaligned addresses are truncated as above.

Test Plan:
- Memory word @0x10000004=0x8899AABB; load byte addr 0x10000006, sign=1 -> resp T+2, rdata 0xFFFFFF99, mem_addr 0x10000004, one mem_re cycle.
- Same word; load half addr 0x10000004, sign=0 -> rdata 0x0000AABB; sign=1 -> 0xFFFFAABB.
- Word 0x11223344 @0x10000000; store byte 0xEE to 0x10000001 -> one re cycle then one we cycle with writedata 0x1122EE44, resp T+3; word readback = 0x1122EE44.
- Word store 0xDEADBEEF to 0x7ffffffc -> single we cycle, resp T+2, req_ready_out=0 for T+1..T+2; back-to-back valid is accepted at the T+3 edge.
- Assert reset during RMW_RD of a half store -> mem_we_out never 1, memory word unchanged, no resp_valid_out, req_ready_out=1 after release.
- MEM_ALIGN_CHECK_EN defined: word load from 0x10000002 -> resp T+2 with resp_fault_out=1, rdata 0, mem_re_out never asserted.
